sid_voice_mixer: RTL and testbench

- Downstream of the three SID voice generators; sits between the voices and the SID filter.
- Snapshots the three signed 12-bit voice outputs and the external input once per ce_1m tick.
- Routes each source to a filter-input sum or a direct sum, then applies master volume to the direct sum.
- Accumulates serially over several fast clocks and emits one result pair per tick with a valid strobe.

---
 rtl/sid_voice_mixer_if.sv | 24 ++
 rtl/sid_voice_mixer.sv | 146 ++++++++++++++
 tb/tb_sid_voice_mixer.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/sid_voice_mixer_if.sv
// Voice/mixer bus between the SID voice generators, the mixer and the filter.
interface sid_voice_mixer_if;
  logic                ce_1m;
  logic signed [11:0]  voice1;
  logic signed [11:0]  voice2;
  logic signed [11:0]  voice3;
  logic signed [11:0]  ext_in;
  logic        [3:0]   res_filt;
  logic        [7:0]   mode_vol;
  logic signed [13:0]  filt_out;
  logic signed [15:0]  mix_out;
  logic                out_valid;
  logic                overrun;

  modport master (
    output ce_1m, voice1, voice2, voice3, ext_in, res_filt, mode_vol,
    input  filt_out, mix_out, out_valid, overrun
  );

  modport slave (
    input  ce_1m, voice1, voice2, voice3, ext_in, res_filt, mode_vol,
    output filt_out, mix_out, out_valid, overrun
  );
endinterface

// File: rtl/sid_voice_mixer.sv
// SID voice mixer: serial filter/direct summing with master volume per ce_1m tick.
// Optional 6581 DC bias on the direct path when SID_MIX_DC_EN is defined.
module sid_voice_mixer #(
  parameter logic signed [13:0] DC_OFFSET = '0
) (
  input  logic               clock,
  input  logic               reset_n,
  sid_voice_mixer_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE, ACC_V1, ACC_V2, ACC_V3, ACC_EXT, SCALE
  } state_t;

  state_t state, state_next;

  logic signed [11:0] v1_s, v2_s, v3_s, ext_s;
  logic        [3:0]  res_s;
  logic        [3:0]  vol_s;
  logic               v3_off_s;

  logic signed [13:0] filt_acc, dir_acc;
  logic signed [13:0] src;
  logic               capture, add_en, to_filt, scale_en, busy_ce;
  logic signed [13:0] dir_sum;
  logic signed [17:0] product;
  logic               unused_mode;

  function automatic logic signed [13:0] sext(input logic signed [11:0] v);
    return {{2{v[11]}}, v};
  endfunction

  always_comb unused_mode = ^bus.mode_vol[6:4];

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    add_en     = 1'b0;
    to_filt    = 1'b0;
    scale_en   = 1'b0;
    src        = '0;
    case (state)
      IDLE: begin
        if (bus.ce_1m) begin
          capture    = 1'b1;
          state_next = ACC_V1;
        end
      end
      ACC_V1: begin
        src        = sext(v1_s);
        add_en     = 1'b1;
        to_filt    = res_s[0];
        state_next = ACC_V2;
      end
      ACC_V2: begin
        src        = sext(v2_s);
        add_en     = 1'b1;
        to_filt    = res_s[1];
        state_next = ACC_V3;
      end
      ACC_V3: begin
        // voice3-off only silences the direct path
        src        = sext(v3_s);
        add_en     = res_s[2] | ~v3_off_s;
        to_filt    = res_s[2];
        state_next = ACC_EXT;
      end
      ACC_EXT: begin
        src        = sext(ext_s);
        add_en     = 1'b1;
        to_filt    = res_s[3];
        state_next = SCALE;
      end
      SCALE: begin
        scale_en   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb busy_ce = bus.ce_1m && (state != IDLE);

`ifdef SID_MIX_DC_EN
  logic signed [14:0] biased;
  always_comb begin
    biased  = {dir_acc[13], dir_acc} + {DC_OFFSET[13], DC_OFFSET};
    dir_sum = biased[13:0];
    if (biased[14] != biased[13])
      dir_sum = biased[14] ? 14'sh2000 : 14'sh1FFF;
  end
`else
  logic unused_dc;
  always_comb unused_dc = ^DC_OFFSET;
  always_comb dir_sum = dir_acc;
`endif

  always_comb product = $signed({{4{dir_sum[13]}}, dir_sum}) * $signed({13'd0, 1'b0, vol_s});

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state         <= IDLE;
      v1_s          <= '0;
      v2_s          <= '0;
      v3_s          <= '0;
      ext_s         <= '0;
      res_s         <= '0;
      vol_s         <= '0;
      v3_off_s      <= 1'b0;
      filt_acc      <= '0;
      dir_acc       <= '0;
      bus.filt_out  <= '0;
      bus.mix_out   <= '0;
      bus.out_valid <= 1'b0;
      bus.overrun   <= 1'b0;
    end else begin
      state         <= state_next;
      bus.out_valid <= 1'b0;
      if (busy_ce)
        bus.overrun <= 1'b1;
      if (capture) begin
        v1_s     <= bus.voice1;
        v2_s     <= bus.voice2;
        v3_s     <= bus.voice3;
        ext_s    <= bus.ext_in;
        res_s    <= bus.res_filt;
        vol_s    <= bus.mode_vol[3:0];
        v3_off_s <= bus.mode_vol[7];
        filt_acc <= '0;
        dir_acc  <= '0;
      end
      if (add_en) begin
        if (to_filt)
          filt_acc <= filt_acc + src;
        else
          dir_acc  <= dir_acc + src;
      end
      if (scale_en) begin
        bus.filt_out  <= filt_acc;
        bus.mix_out   <= product[17:2];
        bus.out_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sid_voice_mixer.sv
// Directed self-checking bench for sid_voice_mixer (DC-bias cases when SID_MIX_DC_EN is defined).
module tb_sid_voice_mixer;

  logic clock = 1'b0;
  logic reset_n;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clock = ~clock;

  sid_voice_mixer_if bus ();

  sid_voice_mixer #(.DC_OFFSET(14'sd0)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

`ifdef SID_MIX_DC_EN
  sid_voice_mixer_if bus_dcn ();
  sid_voice_mixer_if bus_dcp ();

  sid_voice_mixer #(.DC_OFFSET(-14'sd2000)) dut_dcn (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_dcn.slave)
  );

  sid_voice_mixer #(.DC_OFFSET(14'sd8191)) dut_dcp (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_dcp.slave)
  );
`endif

  task automatic set_inputs(input logic signed [11:0] v1, input logic signed [11:0] v2,
                            input logic signed [11:0] v3, input logic signed [11:0] ext,
                            input logic [3:0] rf, input logic [7:0] mv);
    bus.voice1   = v1;
    bus.voice2   = v2;
    bus.voice3   = v3;
    bus.ext_in   = ext;
    bus.res_filt = rf;
    bus.mode_vol = mv;
  endtask

  // ce_1m high for edge 0 (and edge second_at if nonzero); observe the 12 edges that follow.
  task automatic run_tick(input int second_at, input bit scramble,
                          output int lat, output int pulses,
                          output logic signed [13:0] f, output logic signed [15:0] m);
    lat = -1;
    pulses = 0;
    f = '0;
    m = '0;
    bus.ce_1m = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      bus.ce_1m = (second_at != 0) && (i + 1 == second_at);
      if (i == 0 && scramble)
        set_inputs(12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom),
                   4'($urandom), 8'($urandom));
      if (bus.out_valid === 1'b1) begin
        pulses++;
        if (lat < 0) begin
          lat = i;
          f = bus.filt_out;
          m = bus.mix_out;
        end
      end
    end
  endtask

  task automatic test_reset();
    bus.ce_1m = 1'b0;
    set_inputs('0, '0, '0, '0, '0, '0);
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    vectors++; if (bus.filt_out !== 14'sd0) begin miscompares++; $display("FAIL reset_filt: got %0d want 0", bus.filt_out); end
    vectors++; if (bus.mix_out !== 16'sd0) begin miscompares++; $display("FAIL reset_mix: got %0d want 0", bus.mix_out); end
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
    vectors++; if (bus.overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun: got %b want 0", bus.overrun); end
  endtask

  task automatic test_direct_sum();
    int lat, pulses;
    logic signed [13:0] f;
    logic signed [15:0] m;
    set_inputs(12'sd100, 12'sd200, 12'sd300, 12'sd0, 4'b0000, 8'h0F);
    run_tick(0, 1'b0, lat, pulses, f, m);
    vectors++; if (lat !== 5) begin miscompares++; $display("FAIL direct_latency: got %0d want 5", lat); end
    vectors++; if (pulses !== 1) begin miscompares++; $display("FAIL direct_pulses: got %0d want 1", pulses); end
    vectors++; if (f !== 14'sd0) begin miscompares++; $display("FAIL direct_filt: got %0d want 0", f); end
    vectors++; if (m !== 16'sd2250) begin miscompares++; $display("FAIL direct_mix: got %0d want 2250", m); end
    vectors++; if (bus.mix_out !== 16'sd2250) begin miscompares++; $display("FAIL direct_hold: got %0d want 2250", bus.mix_out); end
    vectors++; if (bus.overrun !== 1'b0) begin miscompares++; $display("FAIL direct_overrun: got %b want 0", bus.overrun); end
  endtask

  task automatic test_routing();
    int lat, pulses;
    logic signed [13:0] f;
    logic signed [15:0] m;
    set_inputs(12'sd1000, -12'sd500, 12'sd250, -12'sd100, 4'b0101, 8'h08);
    run_tick(0, 1'b1, lat, pulses, f, m);
    vectors++; if (f !== 14'sd1250) begin miscompares++; $display("FAIL routing_filt: got %0d want 1250", f); end
    vectors++; if (m !== -16'sd1200) begin miscompares++; $display("FAIL routing_mix: got %0d want -1200", m); end
    vectors++; if (pulses !== 1) begin miscompares++; $display("FAIL routing_pulses: got %0d want 1", pulses); end
  endtask

  task automatic test_voice3_off();
    int lat, pulses;
    logic signed [13:0] f;
    logic signed [15:0] m;
    set_inputs(12'sd0, 12'sd0, 12'sd2047, 12'sd0, 4'b0000, 8'h8F);
    run_tick(0, 1'b0, lat, pulses, f, m);
    vectors++; if (m !== 16'sd0) begin miscompares++; $display("FAIL v3off_mix: got %0d want 0", m); end
    vectors++; if (f !== 14'sd0) begin miscompares++; $display("FAIL v3off_filt: got %0d want 0", f); end
    set_inputs(12'sd0, 12'sd0, 12'sd2047, 12'sd0, 4'b0100, 8'h8F);
    run_tick(0, 1'b0, lat, pulses, f, m);
    vectors++; if (f !== 14'sd2047) begin miscompares++; $display("FAIL v3filt_filt: got %0d want 2047", f); end
    vectors++; if (m !== 16'sd0) begin miscompares++; $display("FAIL v3filt_mix: got %0d want 0", m); end
  endtask

  task automatic test_extremes();
    int lat, pulses;
    logic signed [13:0] f;
    logic signed [15:0] m;
    set_inputs(12'sd2047, 12'sd2047, 12'sd2047, 12'sd2047, 4'b0000, 8'h0F);
    run_tick(0, 1'b0, lat, pulses, f, m);
    vectors++; if (m !== 16'sd30705) begin miscompares++; $display("FAIL max_mix: got %0d want 30705", m); end
    set_inputs(-12'sd2048, -12'sd2048, -12'sd2048, -12'sd2048, 4'b0000, 8'h0F);
    run_tick(0, 1'b0, lat, pulses, f, m);
    vectors++; if (m !== -16'sd30720) begin miscompares++; $display("FAIL min_mix: got %0d want -30720", m); end
    set_inputs(-12'sd2048, -12'sd2048, -12'sd2048, -12'sd2048, 4'b1111, 8'h0F);
    run_tick(0, 1'b0, lat, pulses, f, m);
    vectors++; if (f !== -14'sd8192) begin miscompares++; $display("FAIL min_filt: got %0d want -8192", f); end
    vectors++; if (m !== 16'sd0) begin miscompares++; $display("FAIL allfilt_mix: got %0d want 0", m); end
    set_inputs(12'sd2047, 12'sd2047, 12'sd2047, 12'sd2047, 4'b0011, 8'h00);
    run_tick(0, 1'b0, lat, pulses, f, m);
    vectors++; if (m !== 16'sd0) begin miscompares++; $display("FAIL vol0_mix: got %0d want 0", m); end
    vectors++; if (f !== 14'sd4094) begin miscompares++; $display("FAIL vol0_filt: got %0d want 4094", f); end
  endtask

  task automatic test_back_to_back();
    int lat, pulses;
    logic signed [13:0] f;
    logic signed [15:0] m;
    set_inputs(12'sd100, 12'sd200, 12'sd300, 12'sd0, 4'b0000, 8'h0F);
    run_tick(3, 1'b0, lat, pulses, f, m);
    vectors++; if (pulses !== 1) begin miscompares++; $display("FAIL overrun_pulses: got %0d want 1", pulses); end
    vectors++; if (m !== 16'sd2250) begin miscompares++; $display("FAIL overrun_mix: got %0d want 2250", m); end
    vectors++; if (bus.overrun !== 1'b1) begin miscompares++; $display("FAIL overrun_flag: got %b want 1", bus.overrun); end
    set_inputs(12'sd4, 12'sd0, 12'sd0, 12'sd0, 4'b0000, 8'h01);
    run_tick(0, 1'b0, lat, pulses, f, m);
    vectors++; if (bus.overrun !== 1'b1) begin miscompares++; $display("FAIL overrun_sticky: got %b want 1", bus.overrun); end
    vectors++; if (m !== 16'sd1) begin miscompares++; $display("FAIL after_overrun_mix: got %0d want 1", m); end

    set_inputs(12'sd100, 12'sd200, 12'sd300, 12'sd0, 4'b0000, 8'h0F);
    run_tick(0, 1'b0, lat, pulses, f, m);
    bus.ce_1m = 1'b1;
    @(negedge clock);
    bus.ce_1m = 1'b0;
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    vectors++; if (bus.mix_out !== 16'sd0) begin miscompares++; $display("FAIL midreset_mix: got %0d want 0", bus.mix_out); end
    vectors++; if (bus.filt_out !== 14'sd0) begin miscompares++; $display("FAIL midreset_filt: got %0d want 0", bus.filt_out); end
    vectors++; if (bus.overrun !== 1'b0) begin miscompares++; $display("FAIL midreset_overrun: got %b want 0", bus.overrun); end
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (bus.out_valid === 1'b1) pulses++;
    end
    vectors++; if (pulses !== 0) begin miscompares++; $display("FAIL midreset_pulses: got %0d want 0", pulses); end

    run_tick(5, 1'b0, lat, pulses, f, m);
    vectors++; if (bus.overrun !== 1'b1) begin miscompares++; $display("FAIL scale_overrun: got %b want 1", bus.overrun); end
    vectors++; if (pulses !== 1) begin miscompares++; $display("FAIL scale_pulses: got %0d want 1", pulses); end
  endtask

`ifdef SID_MIX_DC_EN
  task automatic test_dc_offset();
    logic signed [15:0] mn, mp;
    bus_dcn.voice1 = '0; bus_dcn.voice2 = '0; bus_dcn.voice3 = '0; bus_dcn.ext_in = '0;
    bus_dcn.res_filt = '0; bus_dcn.mode_vol = 8'h00; bus_dcn.ce_1m = 1'b0;
    bus_dcp.voice1 = 12'sd1000; bus_dcp.voice2 = 12'sd1000; bus_dcp.voice3 = 12'sd1000;
    bus_dcp.ext_in = 12'sd1000; bus_dcp.res_filt = '0; bus_dcp.mode_vol = 8'h01; bus_dcp.ce_1m = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) bus_dcn.mode_vol = 8'h0F;
      bus_dcn.ce_1m = 1'b1;
      bus_dcp.ce_1m = 1'b1;
      mn = 16'sh7FFF;
      mp = 16'sh7FFF;
      for (int i = 0; i < 8; i++) begin
        @(negedge clock);
        bus_dcn.ce_1m = 1'b0;
        bus_dcp.ce_1m = 1'b0;
        if (i == 5 && bus_dcn.out_valid === 1'b1) mn = bus_dcn.mix_out;
        if (i == 5 && bus_dcp.out_valid === 1'b1) mp = bus_dcp.mix_out;
      end
      if (pass == 0) begin
        vectors++; if (mn !== 16'sd0) begin miscompares++; $display("FAIL dc_vol0_mix: got %0d want 0", mn); end
      end else begin
        vectors++; if (mn !== -16'sd7500) begin miscompares++; $display("FAIL dc_vol15_mix: got %0d want -7500", mn); end
      end
      vectors++; if (mp !== 16'sd2047) begin miscompares++; $display("FAIL dc_sat_mix: got %0d want 2047", mp); end
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_direct_sum();
    test_routing();
    test_voice3_off();
    test_extremes();
    test_back_to_back();
`ifdef SID_MIX_DC_EN
    test_dc_offset();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
